// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder sequencer on a one-bit full-adder datapath
// Optional SERIAL_ADDER_SUB_EN adds a sub input for a-b via inverted b and forced carry-in.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // One-bit full-adder cell: the only arithmetic in the block.
    assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        sum_next           = sum_sh >> 1;
        sum_next[WIDTH-1]  = fa_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // Accepting straight out of DONE avoids an idle bubble.
                if (start) begin
                    next_state = RUN;
                    load       = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b_load;
            carry  <= c_load;
            cnt    <= '0;
            sum_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
            sum_sh <= sum_next;
            if (last) begin
                sum_r  <= sum_next;
                cout_r <= fa_c;
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed table-driven bench for serial_adder_ctrl at WIDTH=8
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic ec, input string nm);
        logic [7:0] prev_s;
        logic       prev_c;
        int         lat;
        bit         held;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        prev_s = sum; prev_c = cout; held = 1'b1; lat = -1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        chk({nm, "_busy_run"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (sum !== prev_s || cout !== prev_c) held = 1'b0;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd8);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        chk({nm, "_sum_held"}, 32'(held), 32'd1);
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int         ndone;
        int         lat;
        int         d1;
        int         d2;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       c1;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));
        end

        // start raised mid-run must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat = -1; s1 = '0; c1 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; s1 = sum; c1 = cout;
                end
            end
            if (k == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else begin
                start = 1'b0;
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_latency", 32'(lat), 32'd8);
        chk("ign_sum", 32'(s1), 32'h30);
        chk("ign_cout", 32'(c1), 32'd0);
        chk("ign_busy_after", 32'(busy), 32'd0);

        // start held high: back-to-back results every 9 cycles
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        ndone = 0; d1 = -1; d2 = -1; s1 = '0; s2 = '0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a = 8'h7F; b = 8'h01;
            end
            if (k == 9) begin
                start = 1'b0;
                chk("b2b_busy_no_bubble", 32'(busy), 32'd1);
            end
            if (done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = k; s1 = sum;
                end else begin
                    d2 = k; s2 = sum;
                end
            end
        end
        chk("b2b_ndone", 32'(ndone), 32'd2);
        chk("b2b_first_at", 32'(d1), 32'd8);
        chk("b2b_second_at", 32'(d2), 32'd17);
        chk("b2b_sum1", 32'(s1), 32'h03);
        chk("b2b_sum2", 32'(s2), 32'h80);

        // reset in the middle of a run aborts it
        @(negedge clk);
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        do_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "post_abort");

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        do_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, "sub_borrow");
        do_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub_noborrow");
        sub = 1'b0;
        do_op(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, "sub_off");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
